// File: rtl/relay_pkg.sv
// relay_pkg: shared register indices, instruction classes, FSM states and opcode fields for the register-transfer sequencer
package relay_pkg;
  typedef enum logic [2:0] {R_A, R_B, R_C, R_D, R_M1, R_M2, R_X, R_Y} reg_idx_t;
  typedef enum logic [1:0] {C_MOV8, C_ALU, C_SETAB, C_ILLEGAL} instr_class_t;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_LOAD, S_HOLD, S_DONE, S_ERR} state_t;
  localparam logic [1:0] OP_MOV8  = 2'b00;
  localparam logic [1:0] OP_SETAB = 2'b01;
  localparam logic [3:0] OP_ALU   = 4'b1000;
endpackage

// File: rtl/xfer_decode.sv
// xfer_decode: combinational instr -> {cls, src, dst, clear, alu_fn, imm_value}; clear means MOV8 with src==dst
module xfer_decode
  import relay_pkg::*;
(
  input  logic [7:0]   instr,
  output instr_class_t cls,
  output reg_idx_t     src,
  output reg_idx_t     dst,
  output logic         clear,
  output logic [2:0]   alu_fn,
  output logic [7:0]   imm_value
);
  always_comb begin
    cls = instr[7:6] == OP_MOV8 ? C_MOV8 : instr[7:6] == OP_SETAB ? C_SETAB : instr[7:4] == OP_ALU ? C_ALU : C_ILLEGAL;
    src = reg_idx_t'(instr[2:0]);
    dst = cls == C_MOV8 ? reg_idx_t'(instr[5:3]) : cls == C_ALU ? (instr[3] ? R_D : R_A) : (instr[5] ? R_B : R_A);
    clear = instr[5:3] == instr[2:0];
    alu_fn = instr[2:0];
    imm_value = {{3{instr[4]}}, instr[4:0]};
  end
endmodule

// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: drive bus source, settle, load pulse, hold, release (in: clk reset start instr; out: busy done err ld sel alu_fn alu_to_bus imm_en imm_value)
module reg_xfer_sequencer
  import relay_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] ld,
  output logic [7:0] sel,
  output logic [2:0] alu_fn,
  output logic       alu_to_bus,
  output logic       imm_en,
  output logic [7:0] imm_value
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  instr_class_t d_cls, cls_q, k;
  reg_idx_t d_src, d_dst, src_q, dst_q, src_f, dst_f;
  logic d_clear, clr_q, clr_f, idle, src_on;
  logic [2:0] d_fn, fn_q, fn_f;
  logic [7:0] d_imm, imm_q, imm_f;
  xfer_decode u_dec (
    .instr(instr),
    .cls(d_cls),
    .src(d_src),
    .dst(d_dst),
    .clear(d_clear),
    .alu_fn(d_fn),
    .imm_value(d_imm)
  );
  always_comb begin
    idle = state == S_IDLE;
    k = idle ? d_cls : cls_q;
    src_f = idle ? d_src : src_q;
    dst_f = idle ? d_dst : dst_q;
    clr_f = idle ? d_clear : clr_q;
    fn_f = idle ? d_fn : fn_q;
    imm_f = idle ? d_imm : imm_q;
    nxt = idle ? (start ? (d_cls == C_ILLEGAL ? S_ERR : S_DRIVE) : S_IDLE)
        : state == S_DRIVE ? (cnt == CW'(SETTLE_CYCLES - 1) ? S_LOAD : S_DRIVE)
        : state == S_LOAD ? S_HOLD
        : state == S_HOLD ? S_DONE : S_IDLE;
    src_on = nxt == S_DRIVE || nxt == S_LOAD || nxt == S_HOLD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      cls_q <= C_ILLEGAL;
      src_q <= R_A;
      dst_q <= R_A;
      clr_q <= 1'b0;
      fn_q <= '0;
      imm_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ld <= '0;
      sel <= '0;
      alu_fn <= '0;
      alu_to_bus <= 1'b0;
      imm_en <= 1'b0;
      imm_value <= '0;
    end else begin
      state <= nxt;
      cnt <= state == S_DRIVE && nxt == S_DRIVE ? cnt + CW'(1) : '0;
      if (idle && start) begin
        cls_q <= d_cls;
        src_q <= d_src;
        dst_q <= d_dst;
        clr_q <= d_clear;
        fn_q <= d_fn;
        imm_q <= d_imm;
      end
      busy <= src_on;
      done <= nxt == S_DONE;
      err <= nxt == S_ERR;
      ld <= nxt == S_LOAD ? 8'd1 << dst_f : '0;
      sel <= src_on && k == C_MOV8 && !clr_f ? 8'd1 << src_f : '0;
      alu_fn <= src_on && k == C_ALU ? fn_f : '0;
      alu_to_bus <= src_on && k == C_ALU;
      imm_en <= src_on && k == C_SETAB;
      imm_value <= src_on && k == C_SETAB ? imm_f : '0;
    end
  end
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb_reg_xfer_sequencer: randomized self-checking bench with a cycle-level reference model and a register-file model
module tb_reg_xfer_sequencer;
  localparam int S = 2;
  logic clk, reset, start;
  logic [7:0] instr;
  logic busy, done, err, alu_to_bus, imm_en;
  logic [7:0] ld, sel, imm_value;
  logic [2:0] alu_fn;
  logic [7:0] rf [8];
  int nchk, nerr;

  reg_xfer_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .err(err), .ld(ld), .sel(sel),
    .alu_fn(alu_fn), .alu_to_bus(alu_to_bus), .imm_en(imm_en), .imm_value(imm_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_alu(input logic [2:0] f, input logic [7:0] b, input logic [7:0] c);
    case (f)
      3'd0: return b + c;
      3'd1: return b - c;
      3'd2: return b & c;
      3'd3: return b | c;
      3'd4: return b ^ c;
      3'd5: return ~b;
      3'd6: return b << 1;
      default: return c;
    endcase
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] outs();
    return {busy, done, err, ld, sel, alu_fn, alu_to_bus, imm_en, imm_value};
  endfunction

  function automatic logic [31:0] exp_out(input logic [7:0] ins, input int k);
    logic mov, alu, setab, b, dn, e, a, ie;
    logic [7:0] l, se, imv;
    logic [2:0] f, d;
    mov = ins[7:6] == 2'b00;
    setab = ins[7:6] == 2'b01;
    alu = ins[7:4] == 4'h8;
    {b, dn, e, a, ie, l, se, imv, f, d} = '0;
    if (!(mov || setab || alu)) e = k == 1;
    else begin
      d = mov ? ins[5:3] : alu ? (ins[3] ? 3'd3 : 3'd0) : (ins[5] ? 3'd1 : 3'd0);
      if (k >= 1 && k <= S + 2) begin
        b = 1'b1;
        if (mov && ins[2:0] != ins[5:3]) se = 8'd1 << ins[2:0];
        a = alu;
        f = alu ? ins[2:0] : 3'd0;
        ie = setab;
        imv = setab ? {{3{ins[4]}}, ins[4:0]} : 8'd0;
      end
      if (k == S + 1) l = 8'd1 << d;
      dn = k == S + 3;
    end
    return {b, dn, e, l, se, f, a, ie, imv};
  endfunction

  task automatic apply_rf();
    logic [7:0] bus;
    bus = |sel ? rf[idx_of(sel)] : alu_to_bus ? tb_alu(alu_fn, rf[1], rf[2]) : imm_en ? imm_value : 8'd0;
    if (|ld) rf[idx_of(ld)] = bus;
  endtask

  task automatic run_instr(input logic [7:0] ins, input bit poke);
    logic [7:0] exp_rf [8];
    logic [31:0] got, ex;
    bit legal, same;
    int n;
    legal = ins[7:6] != 2'b11 && (ins[7:6] != 2'b10 || ins[5:4] == 2'b00);
    exp_rf = rf;
    if (ins[7:6] == 2'b00) exp_rf[ins[5:3]] = ins[5:3] == ins[2:0] ? 8'd0 : rf[ins[2:0]];
    else if (ins[7:6] == 2'b01) exp_rf[ins[5] ? 1 : 0] = {{3{ins[4]}}, ins[4:0]};
    else if (legal) exp_rf[ins[3] ? 3 : 0] = tb_alu(ins[2:0], rf[1], rf[2]);
    n = legal ? S + 3 : 1;
    @(negedge clk);
    start = 1'b1;
    instr = ins;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        instr = 8'($urandom);
      end
      got = outs();
      ex = exp_out(ins, k);
      nchk++;
      if (got !== ex) begin
        nerr++;
        $display("FAIL outputs instr=%h k=%0d got=%h exp=%h", ins, k, got, ex);
      end
      nchk++;
      if (!$onehot0(ld) || !$onehot0(sel) || (32'(|sel) + 32'(alu_to_bus) + 32'(imm_en)) > 1) begin
        nerr++;
        $display("FAIL exclusivity instr=%h k=%0d ld=%h sel=%h alu=%b imm=%b exp=at most one", ins, k, ld, sel, alu_to_bus, imm_en);
      end
      apply_rf();
      if (poke && k == 2) begin
        start = 1'b1;
        instr = 8'($urandom_range(0, 127));
      end
      if (k == 3) start = 1'b0;
    end
    if (legal) begin
      same = 1'b1;
      for (int i = 0; i < 8; i++) if (rf[i] !== exp_rf[i]) same = 1'b0;
      nchk++;
      if (!same) begin
        nerr++;
        $display("FAIL regfile instr=%h got A=%h B=%h C=%h D=%h exp A=%h B=%h C=%h D=%h", ins, rf[0], rf[1], rf[2], rf[3], exp_rf[0], exp_rf[1], exp_rf[2], exp_rf[3]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    instr = 8'h01;
    repeat (2) @(negedge clk);
    nchk++;
    if (outs() !== 32'd0) begin
      nerr++;
      $display("FAIL reset_state got=%h exp=%h", outs(), 32'd0);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    rf[1] = 8'h5A;
    run_instr(8'h01, 1'b0);
    nchk++;
    if (rf[0] !== 8'h5A) begin
      nerr++;
      $display("FAIL mov_a_b got=%h exp=%h", rf[0], 8'h5A);
    end
    run_instr(8'h88, 1'b0);
    run_instr(8'h50, 1'b0);
    nchk++;
    if (rf[0] !== 8'hF0) begin
      nerr++;
      $display("FAIL setab_neg got=%h exp=%h", rf[0], 8'hF0);
    end
    rf[2] = 8'h77;
    run_instr(8'h12, 1'b0);
    nchk++;
    if (rf[2] !== 8'h00) begin
      nerr++;
      $display("FAIL clear_c got=%h exp=%h", rf[2], 8'h00);
    end
    run_instr(8'hC0, 1'b0);
    run_instr(8'h3F, 1'b0);
    run_instr(8'h9F, 1'b0);
    run_instr(8'h6F, 1'b0);
  endtask

  task automatic test_busy_start();
    int dones;
    run_instr(8'h23, 1'b1);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    nchk++;
    if (dones != 0) begin
      nerr++;
      $display("FAIL ignored_start extra_active_cycles=%0d exp=0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start = 1'b1;
    instr = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      nchk++;
      if (outs() !== exp_out(8'h01, k)) begin
        nerr++;
        $display("FAIL pre_reset k=%0d got=%h exp=%h", k, outs(), exp_out(8'h01, k));
      end
      apply_rf();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nchk++;
    if (outs() !== 32'd0) begin
      nerr++;
      $display("FAIL reset_mid got=%h exp=%h", outs(), 32'd0);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy || err || |ld || |sel) seen++;
    end
    nchk++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL post_reset_quiet active_cycles=%0d exp=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) run_instr(8'($urandom), 1'($urandom));
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    start = 1'b0;
    instr = 8'h00;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    test_reset();
    test_directed();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
